// File: rtl/seq_pkg.sv
// Shared types for the serial pattern detector.
// FSM state encoding and match counter width.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT0   = 2'd1,
        GOT01  = 2'd2,
        GOT010 = 2'd3
    } state_t;

    localparam int COUNT_W = 7;

endpackage

// File: rtl/seq_detector_if.sv
// Detector control/result bundle.
// master: drives ena/clear/bit_in/bit_push; slave: drives the results.
interface seq_detector_if;
    import seq_pkg::*;

    logic               ena;
    logic               clear;
    logic               bit_in;
    logic               bit_push;
    logic               match_pulse;
    logic [COUNT_W-1:0] match_count;
    logic               count_wrap;
    logic [1:0]         state_show;
    logic               sample_show;

    modport master (
        output ena, clear, bit_in, bit_push,
        input  match_pulse, match_count, count_wrap,
        input  state_show, sample_show
    );

    modport slave (
        input  ena, clear, bit_in, bit_push,
        output match_pulse, match_count, count_wrap,
        output state_show, sample_show
    );

endinterface

// File: rtl/push_debounce.sv
// Push button synchronizer, debouncer and rising-edge pulse.
// raw: async button; level: debounced level; rise: 1-cycle pulse on level 0->1.
module push_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_50MHz,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            // Level follows only after an unbroken run of disagreement.
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    level <= sync[1];
                    rise  <= sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Mealy detector for 01[0*]1 on button-clocked serial bits.
// clk_50MHz/rst plain; bus carries ena/clear/bit_in/bit_push and results.
module seq_detector
    import seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_COUNT       = 99,
    parameter bit OVERLAP         = 1'b1
) (
    input  logic          clk_50MHz,
    input  logic          rst,
    seq_detector_if.slave bus
);

    logic [1:0]         bit_sync;
    logic               b;
    logic               level;
    logic               sample_evt;
    state_t             state;
    logic [COUNT_W-1:0] count;
    logic               pulse;
    logic               wrap;
    logic               hit;

    push_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_push (
        .clk_50MHz(clk_50MHz),
        .rst      (rst),
        .raw      (bus.bit_push),
        .level    (level),
        .rise     (sample_evt)
    );

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) bit_sync <= 2'b00;
        else     bit_sync <= {bit_sync[0], bus.bit_in};
    end

    assign b = bit_sync[1];

    assign hit = sample_evt && bus.ena && b &&
                 (state == GOT01 || state == GOT010);

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            pulse <= 1'b0;
            wrap  <= 1'b0;
        end else if (bus.clear) begin
            // Clear beats a same-cycle sample; that bit is dropped.
            state <= IDLE;
            count <= '0;
            pulse <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            pulse <= 1'b0;
            wrap  <= 1'b0;
            if (sample_evt && bus.ena) begin
                case (state)
                    IDLE:   state <= b ? IDLE : GOT0;
                    GOT0:   state <= b ? GOT01 : GOT0;
                    GOT01:  state <= b ? IDLE : GOT010;
                    GOT010: state <= b ? (OVERLAP ? GOT01 : IDLE)
                                       : GOT010;
                    default: state <= IDLE;
                endcase
            end
            if (hit) begin
                pulse <= 1'b1;
                if (count == COUNT_W'(MAX_COUNT)) begin
                    count <= '0;
                    wrap  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign bus.match_pulse = pulse;
    assign bus.match_count = count;
    assign bus.count_wrap  = wrap;
    assign bus.state_show  = state;
    assign bus.sample_show = sample_evt;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector (DEBOUNCE_CYCLES=4).
// Two instances: OVERLAP=1 (main) and OVERLAP=0 sharing the stimulus.
module tb_seq_detector;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_detector_if bus ();
    seq_detector_if bus_no ();

    assign bus_no.ena      = bus.ena;
    assign bus_no.clear    = bus.clear;
    assign bus_no.bit_in   = bus.bit_in;
    assign bus_no.bit_push = bus.bit_push;

    seq_detector #(
        .DEBOUNCE_CYCLES(4),
        .MAX_COUNT      (99),
        .OVERLAP        (1'b1)
    ) dut (
        .clk_50MHz(clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    seq_detector #(
        .DEBOUNCE_CYCLES(4),
        .MAX_COUNT      (99),
        .OVERLAP        (1'b0)
    ) dut_no (
        .clk_50MHz(clk),
        .rst      (rst),
        .bus      (bus_no.slave)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulses_no = 0;
    int wraps = 0;
    int wrap_bad = 0;
    int samples = 0;

    always @(negedge clk) begin
        if (bus.match_pulse) pulses++;
        if (bus_no.match_pulse) pulses_no++;
        if (bus.count_wrap) wraps++;
        if (bus.count_wrap && !bus.match_pulse) wrap_bad++;
        if (bus.sample_show) samples++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic b);
        bus.bit_in = b;
        repeat (3) @(negedge clk);
        bus.bit_push = 1'b1;
        repeat (10) @(negedge clk);
        bus.bit_push = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        @(negedge clk);
    endtask

    int p0, pn, s0, w0;
    bit seen;

    initial begin
        rst          = 1'b1;
        bus.ena      = 1'b1;
        bus.clear    = 1'b0;
        bus.bit_in   = 1'b0;
        bus.bit_push = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", bus.match_count, 0);
        check("rst_state", bus.state_show, 0);
        check("rst_pulse", {bus.match_pulse, bus.count_wrap,
                            bus.sample_show}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: 0,1,1
        press(1'b0);
        check("t1_state_b1", bus.state_show, 1);
        press(1'b1);
        check("t1_state_b2", bus.state_show, 2);
        check("t1_no_early", pulses, 0);
        press(1'b1);
        check("t1_pulses", pulses, 1);
        check("t1_count", bus.match_count, 1);
        check("t1_state", bus.state_show, 0);
        check("t1_samples", samples, 3);

        // 2: 0,1,0,0,1,0,1 on both overlap modes
        do_clear();
        check("t2_clr_no", bus_no.match_count, 0);
        p0 = pulses;
        pn = pulses_no;
        press(1'b0);
        press(1'b1);
        press(1'b0);
        press(1'b0);
        check("t2_state_b4", bus.state_show, 3);
        press(1'b1);
        check("t2_ov_b5", pulses - p0, 1);
        check("t2_no_b5", pulses_no - pn, 1);
        press(1'b0);
        press(1'b1);
        check("t2_ov_pulses", pulses - p0, 2);
        check("t2_ov_count", bus.match_count, 2);
        check("t2_ov_state", bus.state_show, 2);
        check("t2_no_pulses", pulses_no - pn, 1);
        check("t2_no_count", bus_no.match_count, 1);
        check("t2_no_state", bus_no.state_show, 2);

        // 3: glitches then one clean press
        do_clear();
        s0 = samples;
        bus.bit_in = 1'b0;
        for (int r = 0; r < 6; r++) begin
            bus.bit_push = 1'b1;
            repeat ((r % 3) + 1) @(negedge clk);
            bus.bit_push = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("t3_glitch_smp", samples - s0, 0);
        check("t3_glitch_st", bus.state_show, 0);
        press(1'b0);
        check("t3_press_smp", samples - s0, 1);
        check("t3_press_st", bus.state_show, 1);

        // 4: 100 sequences wrap the count once
        do_clear();
        w0 = wraps;
        p0 = pulses;
        for (int s = 0; s < 99; s++) begin
            press(1'b0);
            press(1'b1);
            press(1'b1);
        end
        check("t4_count99", bus.match_count, 99);
        check("t4_nowrap", wraps - w0, 0);
        press(1'b0);
        press(1'b1);
        press(1'b1);
        check("t4_count0", bus.match_count, 0);
        check("t4_wraps", wraps - w0, 1);
        check("t4_pulses", pulses - p0, 100);
        check("t4_wrap_coinc", wrap_bad, 0);

        // 5: clear in the sample cycle of a matching 1
        do_clear();
        press(1'b0);
        press(1'b1);
        check("t5_state_pre", bus.state_show, 2);
        p0 = pulses;
        bus.bit_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.bit_push = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.sample_show) begin
                seen = 1'b1;
                break;
            end
        end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("t5_evt_seen", seen, 1);
        repeat (8) @(negedge clk);
        bus.bit_push = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_pulses", pulses - p0, 0);
        check("t5_count", bus.match_count, 0);
        check("t5_state", bus.state_show, 0);

        // 6: async reset mid-sequence, then ena=0
        for (int s = 0; s < 5; s++) begin
            press(1'b0);
            press(1'b1);
            press(1'b1);
        end
        press(1'b0);
        press(1'b1);
        press(1'b0);
        check("t6_state_pre", bus.state_show, 3);
        check("t6_count_pre", bus.match_count, 5);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_state", bus.state_show, 0);
        check("t6_rst_count", bus.match_count, 0);
        check("t6_rst_misc", {bus.match_pulse, bus.count_wrap,
                              bus.sample_show}, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.ena = 1'b0;
        p0 = pulses;
        s0 = samples;
        press(1'b0);
        press(1'b1);
        press(1'b1);
        check("t6_ena_smp", samples - s0, 3);
        check("t6_ena_pulses", pulses - p0, 0);
        check("t6_ena_state", bus.state_show, 0);
        check("t6_ena_count", bus.match_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
